// File: rtl/gj_uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and the
// upper bound on the number of requesters.
package gj_uart_pkg;

  localparam int MAX_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    PDN   = 2'd2,
    SLEEP = 2'd3
  } state_t;

endpackage

// File: rtl/gj_rr_pick.sv
// Combinational round-robin picker. Rotates the request vector right by
// ptr, isolates the lowest set bit, then rotates the result back, so the
// first requester at or after ptr (modulo N) wins. All zero with no request.
module gj_rr_pick
  import gj_uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] rot;
  logic [N-1:0] first;

  // Double-width rotate, lowest-bit isolate, rotate back.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    first = rot & (~rot + N'(1));
    grant = N'(({first, first} << ptr) >> N);
  end

endmodule

// File: rtl/gj_uart_tx_arb.sv
// Frame-granular round-robin arbiter sharing one UART transmitter between
// N AXI-Stream requesters. A grant is held from a frame's first beat to its
// tlast beat; frames longer than MAX_LEN are cut with a forced tlast and
// flagged in err_len.
// Optional transmitter power-down sequencing is built when the macro
// GJ_UART_ARB_PWRDN_EN is defined.
module gj_uart_tx_arb
  import gj_uart_pkg::*;
#(
  parameter int N       = 4,
  parameter int MAX_LEN = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  input  logic [N-1:0]   s_tvalid,
  output logic [N-1:0]   s_tready,
  input  logic [8*N-1:0] s_tdata,
  input  logic [N-1:0]   s_tlast,
  output logic           m_tvalid,
  input  logic           m_tready,
  output logic [7:0]     m_tdata,
  output logic           m_tlast,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           err_len,
  input  logic           err_clr
`ifdef GJ_UART_ARB_PWRDN_EN
  ,
  input  logic [15:0]    idle_nop,
  output logic           powerDown_tvalid,
  input  logic           powerDown_tready
`endif
);

  localparam int          PW        = $clog2(N);
  localparam logic [15:0] LAST_BEAT = 16'(MAX_LEN - 1);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("gj_uart_tx_arb: N must be within 2..MAX_N");
  end

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   ptr_nxt;
  logic [15:0]     beat_cnt;
  logic [N-1:0]    pick;
  logic            any_req;
  logic            take_grant;
  logic            sel_last;
  logic            hs;
  logic            hs_last;

  assign any_req = |s_tvalid;
  assign busy    = (state == XFER);
  assign hs      = m_tvalid & m_tready;
  assign hs_last = hs & m_tlast;

`ifdef GJ_UART_ARB_PWRDN_EN
  logic [15:0] idle_cnt;
  assign take_grant = any_req & ((state == IDLE) | (state == SLEEP));
`else
  logic unused_clk_en;
  assign unused_clk_en = clk_en;
  assign take_grant    = any_req & (state == IDLE);
`endif

  gj_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req   (s_tvalid),
    .ptr   (ptr),
    .grant (pick)
  );

  // Encode the one-hot owner as an index and compute the pointer after it.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
    ptr_nxt = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: each combinational output is given a default first so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req) state_nxt = XFER;
`ifdef GJ_UART_ARB_PWRDN_EN
        else if (idle_nop != 16'd0 && idle_cnt == idle_nop) state_nxt = PDN;
`endif
      end
      XFER: begin
        if (hs_last) state_nxt = IDLE;
      end
`ifdef GJ_UART_ARB_PWRDN_EN
      PDN: begin
        if (powerDown_tready) state_nxt = SLEEP;
      end
      SLEEP: begin
        if (any_req) state_nxt = XFER;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Output mux: pass the granted requester straight through while in XFER.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = 8'h00;
    m_tlast  = 1'b0;
    sel_last = 1'b0;
    s_tready = '0;
    if (state == XFER) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          m_tvalid = s_tvalid[i];
          m_tdata  = s_tdata[8*i +: 8];
          sel_last = s_tlast[i];
        end
      end
      m_tlast  = sel_last | (beat_cnt == LAST_BEAT);
      s_tready = grant & {N{m_tready}};
    end
`ifdef GJ_UART_ARB_PWRDN_EN
    powerDown_tvalid = (state == PDN);
`endif
  end

  // Grant, round-robin pointer and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else if (take_grant) begin
      grant    <= pick;
      beat_cnt <= '0;
    end else if (hs) begin
      if (beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
      if (m_tlast) begin
        grant <= '0;
        ptr   <= ptr_nxt;
      end
    end
  end

  // Sticky truncation flag; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err_len <= 1'b0;
    else if (hs_last & ~sel_last) err_len <= 1'b1;
    else if (err_clr)            err_len <= 1'b0;
  end

`ifdef GJ_UART_ARB_PWRDN_EN
  // Idle timer: counts baud ticks only while idle with nothing requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               idle_cnt <= '0;
    else if (state != IDLE || any_req)        idle_cnt <= '0;
    else if (state_nxt == PDN)                idle_cnt <= '0;
    else if (clk_en)                          idle_cnt <= idle_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_gj_uart_tx_arb.sv
// Self-checking bench for gj_uart_tx_arb (N=4, MAX_LEN=4). A frame-level
// reference model runs every cycle; directed scenarios add literal
// expectations. Power-down checks build only with GJ_UART_ARB_PWRDN_EN.
`timescale 1ns/1ps
module tb_gj_uart_tx_arb;

  localparam int N       = 4;
  localparam int MAX_LEN = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clk_en;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tready;
  logic [8*N-1:0] s_tdata;
  logic [N-1:0]   s_tlast;
  logic           m_tvalid;
  logic           m_tready;
  logic [7:0]     m_tdata;
  logic           m_tlast;
  logic [N-1:0]   grant;
  logic           busy;
  logic           err_len;
  logic           err_clr;
`ifdef GJ_UART_ARB_PWRDN_EN
  logic [15:0]    idle_nop;
  logic           powerDown_tvalid;
  logic           powerDown_tready;
`endif

  gj_uart_tx_arb #(
    .N       (N),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .grant    (grant),
    .busy     (busy),
    .err_len  (err_len),
    .err_clr  (err_clr)
`ifdef GJ_UART_ARB_PWRDN_EN
    ,
    .idle_nop         (idle_nop),
    .powerDown_tvalid (powerDown_tvalid),
    .powerDown_tready (powerDown_tready)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit model_on    = 1'b1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  int mdl_owner = -1;  // requester currently owning the line, -1 if none
  int mdl_ptr   = 0;
  int mdl_beats = 0;
  bit mdl_err   = 1'b0;

  task automatic model_cycle();
    logic         ev, el;
    logic [7:0]   ed;
    logic [N-1:0] er, eg;
    bit           set_err;
    int           idx;
    ev = 0; el = 0; ed = 0; er = 0; eg = 0; set_err = 0;
    if (!rst_n) begin
      mdl_owner = -1; mdl_ptr = 0; mdl_beats = 0; mdl_err = 0;
    end else if (mdl_owner >= 0) begin
      ev = s_tvalid[mdl_owner];
      ed = s_tdata[8*mdl_owner +: 8];
      el = s_tlast[mdl_owner] || (mdl_beats == MAX_LEN - 1);
      er = m_tready ? N'(1 << mdl_owner) : '0;
      eg = N'(1 << mdl_owner);
    end
    check("m_tvalid", m_tvalid, ev);
    check("m_tdata", m_tdata, ed);
    check("m_tlast", m_tlast, el);
    check("s_tready", s_tready, er);
    check("grant", grant, eg);
    check("busy", busy, mdl_owner >= 0);
    check("err_len", err_len, mdl_err);
`ifdef GJ_UART_ARB_PWRDN_EN
    check("powerDown_tvalid", powerDown_tvalid, 0);
`endif
    if (!rst_n) return;
    if (mdl_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (mdl_ptr + k) % N;
        if (s_tvalid[idx] && mdl_owner < 0) begin
          mdl_owner = idx;
          mdl_beats = 0;
        end
      end
    end else if (s_tvalid[mdl_owner] && m_tready) begin
      mdl_beats++;
      if (el) begin
        set_err   = !s_tlast[mdl_owner];
        mdl_ptr   = (mdl_owner + 1) % N;
        mdl_owner = -1;
      end
    end
    mdl_err = set_err ? 1'b1 : (err_clr ? 1'b0 : mdl_err);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (model_on) model_cycle();
    end
  end

  // ---------------- directed stimulus engine ----------------
  logic [7:0]   dq [N][$];
  bit           lq [N][$];
  int           start_at [N];
  int           gap_after [N];
  int           gap_left [N];
  int           sent [N];
  bit           tready_toggle;
  logic [N-1:0] gh [$];
  bit           bh [$];
  logic [7:0]   od [$];
  bit           ol [$];
  logic [7:0]   ed [$];
  bit           el [$];
  logic [N-1:0] hs_prev;

  task automatic idle_inputs();
    s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    m_tready = 1'b1; err_clr = 1'b0; clk_en = 1'b0;
`ifdef GJ_UART_ARB_PWRDN_EN
    idle_nop = 16'd0; powerDown_tready = 1'b0;
`endif
  endtask

  task automatic clear_dir();
    for (int i = 0; i < N; i++) begin
      dq[i].delete(); lq[i].delete();
      start_at[i] = 0; gap_after[i] = 0; gap_left[i] = 0; sent[i] = 0;
    end
    gh.delete(); bh.delete(); od.delete(); ol.delete();
    ed.delete(); el.delete();
    tready_toggle = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_directed(int cycles);
    logic [7:0] prev_d;
    bit         stalled;
    stalled = 1'b0;
    prev_d  = 8'h00;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      m_tready = tready_toggle ? c[0] : 1'b1;
      for (int i = 0; i < N; i++) begin
        s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tdata[8*i +: 8] = 8'h00;
        if (c >= start_at[i] && dq[i].size() > 0) begin
          if (sent[i] == gap_after[i] && gap_left[i] > 0) begin
            gap_left[i]--;
          end else begin
            s_tvalid[i]       = 1'b1;
            s_tdata[8*i +: 8] = dq[i][0];
            s_tlast[i]        = lq[i][0];
          end
        end
      end
      @(negedge clk);
      gh.push_back(grant);
      bh.push_back(busy);
      if (stalled) check("stall_hold_data", m_tdata, prev_d);
      stalled = m_tvalid && !m_tready;
      prev_d  = m_tdata;
      if (m_tvalid && m_tready) begin
        od.push_back(m_tdata);
        ol.push_back(m_tlast);
      end
      if (grant[1]) check("no_interleave_sready0", s_tready[0], 0);
      for (int i = 0; i < N; i++) begin
        if (s_tvalid[i] && s_tready[i]) begin
          void'(dq[i].pop_front());
          void'(lq[i].pop_front());
          sent[i]++;
        end
      end
    end
  endtask

  task automatic cmp_stream(string tag);
    check({tag, "_count"}, od.size(), ed.size());
    for (int k = 0; k < ed.size(); k++) begin
      if (k < od.size()) begin
        check({tag, "_data"}, od[k], ed[k]);
        check({tag, "_last"}, ol[k], el[k]);
      end
    end
  endtask

  logic [N-1:0] fair_exp [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0,
                                  4'h4, 4'h0, 4'h8, 4'h0, 4'h1};

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    clear_dir();

    // Single requester: requester 2 sends A1, A2, A3(last).
    do_reset();
    dq[2] = '{8'hA1, 8'hA2, 8'hA3};
    lq[2] = '{1'b0, 1'b0, 1'b1};
    run_directed(6);
    check("single_grant_c0", gh[0], 4'b0000);
    check("single_grant_c1", gh[1], 4'b0100);
    check("single_grant_c3", gh[3], 4'b0100);
    check("single_grant_c4", gh[4], 4'b0000);
    check("single_busy_c1", bh[1], 1);
    check("single_busy_c4", bh[4], 0);
    ed = '{8'hA1, 8'hA2, 8'hA3};
    el = '{1'b0, 1'b0, 1'b1};
    cmp_stream("single");

    // Fairness: all requesters valid with 1-byte frames.
    clear_dir();
    do_reset();
    for (int i = 0; i < N; i++) begin
      for (int f = 0; f < 3; f++) begin
        dq[i].push_back(8'(8'h10 + i));
        lq[i].push_back(1'b1);
      end
    end
    run_directed(10);
    for (int c = 0; c < 10; c++) check("fairness_grant", gh[c], fair_exp[c]);
    ed = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    el = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    cmp_stream("fairness");

    // No interleave: requester 1 pauses 5 cycles mid-frame, requester 0 waits.
    clear_dir();
    do_reset();
    dq[1] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    lq[1] = '{1'b0, 1'b0, 1'b0, 1'b1};
    gap_after[1] = 2; gap_left[1] = 5;
    dq[0] = '{8'h55};
    lq[0] = '{1'b1};
    start_at[0] = 1;
    run_directed(14);
    for (int c = 1; c <= 9; c++) check("no_interleave_hold", gh[c], 4'b0010);
    ed = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h55};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    cmp_stream("no_interleave");
    check("no_interleave_err", err_len, 0);

    // Backpressure: m_tready toggles every cycle.
    clear_dir();
    do_reset();
    dq[2] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    lq[2] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tready_toggle = 1'b1;
    run_directed(12);
    ed = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    el = '{1'b0, 1'b0, 1'b0, 1'b1};
    cmp_stream("backpressure");

    // Length guard: 6-byte frame against MAX_LEN=4.
    clear_dir();
    do_reset();
    dq[3] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    lq[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_directed(9);
    ed = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    cmp_stream("len_guard");
    check("len_guard_gap_grant", gh[5], 4'b0000);
    check("len_guard_regrant", gh[6], 4'b1000);
    check("len_guard_err_set", err_len, 1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(negedge clk);
    check("len_guard_err_before_clr", err_len, 1);
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("len_guard_err_cleared", err_len, 0);

`ifdef GJ_UART_ARB_PWRDN_EN
    // Power-down sequencing: idle_nop = 3 with a baud tick every cycle.
    clear_dir();
    model_on = 1'b0;
    do_reset();
    idle_nop = 16'd3;
    clk_en   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pdn_not_yet", powerDown_tvalid, 0);
    @(negedge clk);
    check("pdn_asserted", powerDown_tvalid, 1);
    repeat (3) begin
      @(negedge clk);
      check("pdn_held", powerDown_tvalid, 1);
    end
    @(posedge clk); #1;
    powerDown_tready = 1'b1;
    s_tvalid = 4'b1000; s_tdata[31:24] = 8'hE7; s_tlast = 4'b1000;
    @(negedge clk);
    check("pdn_request_waits", grant, 4'b0000);
    @(posedge clk); #1;
    powerDown_tready = 1'b0;
    @(negedge clk);
    check("sleep_pdn_low", powerDown_tvalid, 0);
    check("sleep_no_grant_yet", grant, 4'b0000);
    @(negedge clk);
    check("sleep_wake_grant", grant, 4'b1000);
    check("sleep_wake_data", m_tdata, 8'hE7);
    model_on = 1'b1;
`endif

    // Reset asserted mid-frame: outputs return to reset values immediately.
    clear_dir();
    do_reset();
    s_tvalid = 4'b0001; s_tdata[7:0] = 8'h77; s_tlast = 4'b0000;
    m_tready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_pre_mtvalid", m_tvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_mtvalid", m_tvalid, 0);
    check("midrst_mtlast", m_tlast, 0);
    check("midrst_mtdata", m_tdata, 8'h00);
    check("midrst_grant", grant, 4'b0000);
    check("midrst_busy", busy, 0);
    check("midrst_sready", s_tready, 4'b0000);
`ifdef GJ_UART_ARB_PWRDN_EN
    check("midrst_pdn", powerDown_tvalid, 0);
`endif
    idle_inputs();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic against the model, with occasional resets.
    hs_prev = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      rst_n = ((cyc % 700) != 350);
      for (int i = 0; i < N; i++) begin
        if (!(s_tvalid[i] && !hs_prev[i])) begin
          s_tvalid[i]       = ($urandom_range(0, 3) != 0);
          s_tdata[8*i +: 8] = 8'($urandom);
          s_tlast[i]        = ($urandom_range(0, 5) == 0);
        end
      end
      m_tready = ($urandom_range(0, 3) != 0);
      err_clr  = ($urandom_range(0, 9) == 0);
      clk_en   = 1'($urandom_range(0, 1));
      @(negedge clk);
      hs_prev = s_tvalid & s_tready;
    end

    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
